vscale_hasti_arbiter: RTL and testbench

Two-master, one-slave HASTI (AHB-Lite subset) arbiter that shares a single HASTI bus between two HASTI bridges, e.g. the instruction-fetch and data-memory bridges of one core, or two cores. It selects the address-phase owner each transfer, tracks the data-phase owner, steers the write-data, read-data, ready and response signals, and buffers a completed data phase when its master is stalled for arbitration. It supports only single transfers; burst, lock and protection outputs are constant.

---
 rtl/vscale_hasti_arbiter.sv | 139 +++++++++++++
 tb/tb_vscale_hasti_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vscale_hasti_arbiter.sv
// Two-master, one-slave HASTI arbiter: grants the address phase, tracks the data-phase
// owner, steers data/ready/response, and buffers data phases of arbitration-stalled masters.
module vscale_hasti_arbiter #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic [31:0] m0_haddr,
  input  logic        m0_hwrite,
  input  logic [2:0]  m0_hsize,
  input  logic [1:0]  m0_htrans,
  input  logic [31:0] m0_hwdata,
  output logic [31:0] m0_hrdata,
  output logic        m0_hready,
  output logic        m0_hresp,
  input  logic [31:0] m1_haddr,
  input  logic        m1_hwrite,
  input  logic [2:0]  m1_hsize,
  input  logic [1:0]  m1_htrans,
  input  logic [31:0] m1_hwdata,
  output logic [31:0] m1_hrdata,
  output logic        m1_hready,
  output logic        m1_hresp,
  output logic [31:0] haddr,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [1:0]  htrans,
  output logic [31:0] hwdata,
  output logic [2:0]  hburst,
  output logic        hmastlock,
  output logic [3:0]  hprot,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp
);

  localparam int unsigned DW = 32;
  localparam int unsigned NM = 2;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  logic [NM-1:0]         req_c;
  logic                  gnt_c;

  logic                  ap_lock_q, ap_lock_d;
  logic                  ap_owner_q, ap_owner_d;
  logic                  dp_valid_q, dp_valid_d;
  logic                  dp_owner_q, dp_owner_d;
  logic                  prio_q, prio_d;
  logic [NM-1:0]         held_q, held_d;
  logic [NM-1:0][DW-1:0] hold_rdata_q, hold_rdata_d;
  logic [NM-1:0]         hold_resp_q, hold_resp_d;

  assign req_c = {m1_htrans[1], m0_htrans[1]};

  // Grant: a locked address phase keeps its owner through slave wait states.
  always_comb begin
    gnt_c = 1'b0;
    if (ap_lock_q) begin
      gnt_c = ap_owner_q;
    end else if (req_c[0] && req_c[1]) begin
      gnt_c = ROUND_ROBIN ? prio_q : 1'b0;
    end else if (req_c[1]) begin
      gnt_c = 1'b1;
    end
  end

  assign haddr  = gnt_c ? m1_haddr  : m0_haddr;
  assign hwrite = gnt_c ? m1_hwrite : m0_hwrite;
  assign hsize  = gnt_c ? m1_hsize  : m0_hsize;
  assign htrans = gnt_c ? (req_c[1] ? m1_htrans : HTRANS_IDLE)
                        : (req_c[0] ? m0_htrans : HTRANS_IDLE);
  assign hwdata = (dp_valid_q && dp_owner_q) ? m1_hwdata : m0_hwdata;

  assign hburst    = 3'b000;
  assign hmastlock = 1'b0;
  assign hprot     = 4'b0000;

  assign m0_hready = hready & ~(req_c[0] & gnt_c);
  assign m1_hready = hready & ~(req_c[1] & ~gnt_c);
  assign m0_hrdata = held_q[0] ? hold_rdata_q[0] : hrdata;
  assign m1_hrdata = held_q[1] ? hold_rdata_q[1] : hrdata;
  assign m0_hresp  = held_q[0] ? hold_resp_q[0] : (dp_valid_q & ~dp_owner_q & hresp);
  assign m1_hresp  = held_q[1] ? hold_resp_q[1] : (dp_valid_q & dp_owner_q & hresp);

  // Next state: lock, data-phase tracking, priority and per-master hold buffers.
  always_comb begin
    ap_lock_d    = ap_lock_q;
    ap_owner_d   = ap_owner_q;
    dp_valid_d   = dp_valid_q;
    dp_owner_d   = dp_owner_q;
    prio_d       = prio_q;
    held_d       = held_q;
    hold_rdata_d = hold_rdata_q;
    hold_resp_d  = hold_resp_q;
    if (hready) begin
      ap_lock_d  = 1'b0;
      dp_valid_d = htrans[1];
      dp_owner_d = gnt_c;
      if (htrans[1]) begin
        prio_d = ~gnt_c;
      end
      for (int i = 0; i < NM; i++) begin
        if (dp_valid_q && (dp_owner_q == 1'(i)) && req_c[i] && (gnt_c != 1'(i))) begin
          held_d[i]       = 1'b1;
          hold_rdata_d[i] = hrdata;
          hold_resp_d[i]  = hresp;
        end else if ((gnt_c == 1'(i)) && req_c[i]) begin
          held_d[i] = 1'b0;
        end
      end
    end else if (htrans[1]) begin
      ap_lock_d  = 1'b1;
      ap_owner_d = gnt_c;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      ap_lock_q    <= 1'b0;
      ap_owner_q   <= 1'b0;
      dp_valid_q   <= 1'b0;
      dp_owner_q   <= 1'b0;
      prio_q       <= 1'b0;
      held_q       <= '0;
      hold_rdata_q <= '0;
      hold_resp_q  <= '0;
    end else begin
      ap_lock_q    <= ap_lock_d;
      ap_owner_q   <= ap_owner_d;
      dp_valid_q   <= dp_valid_d;
      dp_owner_q   <= dp_owner_d;
      prio_q       <= prio_d;
      held_q       <= held_d;
      hold_rdata_q <= hold_rdata_d;
      hold_resp_q  <= hold_resp_d;
    end
  end

endmodule

// File: tb/tb_vscale_hasti_arbiter.sv
// Bench for vscale_hasti_arbiter: directed scenarios with fixed expectations plus
// randomized traffic against a per-cycle behavioural model of the arbitration rules.
module tb_vscale_hasti_arbiter;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [31:0] maddr [2];
  logic        mwrite[2];
  logic [2:0]  msize [2];
  logic [1:0]  mtrans[2];
  logic [31:0] mwdata[2];
  logic [31:0] m0_hrdata, m1_hrdata;
  logic        m0_hready, m1_hready, m0_hresp, m1_hresp;
  logic [31:0] haddr, hwdata, s_hrdata;
  logic        hwrite, hmastlock, s_hready, s_hresp;
  logic [2:0]  hsize, hburst;
  logic [1:0]  htrans;
  logic [3:0]  hprot;

  int checks = 0;
  int errors = 0;

  // Model state
  bit          m_lock, m_owner, m_dpv, m_dpo, m_prio;
  bit          m_held[2];
  logic [31:0] m_hrd[2];
  bit          m_hrsp[2];
  // Model expectations for the current cycle
  int          e_gnt;
  logic [31:0] e_haddr, e_hwdata;
  logic        e_hwrite;
  logic [2:0]  e_hsize;
  logic [1:0]  e_htrans;
  logic        e_hready[2];
  logic [31:0] e_hrdata[2];
  logic        e_hresp[2];

  vscale_hasti_arbiter #(.ROUND_ROBIN(1'b1)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .m0_haddr(maddr[0]), .m0_hwrite(mwrite[0]), .m0_hsize(msize[0]), .m0_htrans(mtrans[0]),
    .m0_hwdata(mwdata[0]), .m0_hrdata(m0_hrdata), .m0_hready(m0_hready), .m0_hresp(m0_hresp),
    .m1_haddr(maddr[1]), .m1_hwrite(mwrite[1]), .m1_hsize(msize[1]), .m1_htrans(mtrans[1]),
    .m1_hwdata(mwdata[1]), .m1_hrdata(m1_hrdata), .m1_hready(m1_hready), .m1_hresp(m1_hresp),
    .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .htrans(htrans), .hwdata(hwdata),
    .hburst(hburst), .hmastlock(hmastlock), .hprot(hprot),
    .hrdata(s_hrdata), .hready(s_hready), .hresp(s_hresp)
  );

  always #5 hclk = ~hclk;

  function automatic bit req(int i);
    return mtrans[i][1];
  endfunction

  function automatic int model_gnt();
    if (m_lock) return int'(m_owner);
    if (req(0) && req(1)) return int'(m_prio);
    if (req(1)) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_lock = 0; m_owner = 0; m_dpv = 0; m_dpo = 0; m_prio = 0;
    for (int i = 0; i < 2; i++) begin m_held[i] = 0; m_hrd[i] = '0; m_hrsp[i] = 0; end
  endtask

  task automatic model_eval();
    e_gnt    = model_gnt();
    e_htrans = req(e_gnt) ? mtrans[e_gnt] : 2'b00;
    e_haddr  = maddr[e_gnt];
    e_hwrite = mwrite[e_gnt];
    e_hsize  = msize[e_gnt];
    e_hwdata = (m_dpv && m_dpo) ? mwdata[1] : mwdata[0];
    for (int i = 0; i < 2; i++) begin
      e_hready[i] = s_hready && !(req(i) && e_gnt != i);
      e_hrdata[i] = m_held[i] ? m_hrd[i] : s_hrdata;
      e_hresp[i]  = m_held[i] ? m_hrsp[i] : ((m_dpv && int'(m_dpo) == i) ? s_hresp : 1'b0);
    end
  endtask

  // Advance one clock, applying the model's update rules to the pre-edge inputs.
  task automatic step();
    bit n_lock, n_owner, n_dpv, n_dpo, n_prio, n_held[2], n_hrsp[2];
    logic [31:0] n_hrd[2];
    model_eval();
    n_lock = m_lock; n_owner = m_owner; n_dpv = m_dpv; n_dpo = m_dpo; n_prio = m_prio;
    n_held = m_held; n_hrd = m_hrd; n_hrsp = m_hrsp;
    if (s_hready) begin
      n_lock = 0;
      n_dpv  = e_htrans[1];
      n_dpo  = (e_gnt == 1);
      if (e_htrans[1]) n_prio = (e_gnt == 0);
      for (int i = 0; i < 2; i++) begin
        if (m_dpv && int'(m_dpo) == i && req(i) && e_gnt != i) begin
          n_held[i] = 1; n_hrd[i] = s_hrdata; n_hrsp[i] = s_hresp;
        end else if (e_gnt == i && req(i)) begin
          n_held[i] = 0;
        end
      end
    end else if (e_htrans[1]) begin
      n_lock = 1; n_owner = (e_gnt == 1);
    end
    @(posedge hclk);
    if (hresetn) begin
      m_lock = n_lock; m_owner = n_owner; m_dpv = n_dpv; m_dpo = n_dpo; m_prio = n_prio;
      m_held = n_held; m_hrd = n_hrd; m_hrsp = n_hrsp;
    end
    #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 2; i++) begin
      maddr[i] = '0; mwrite[i] = 0; msize[i] = 3'd2; mtrans[i] = 2'b00; mwdata[i] = '0;
    end
    s_hrdata = '0; s_hready = 1; s_hresp = 0;
  endtask

  task automatic do_reset();
    idle_all();
    hresetn = 0;
    #1;
    model_reset();
    hresetn = 1;
    #1;
  endtask

  task automatic test_reset();
    idle_all();
    hresetn = 0;
    #2;
    model_reset();
    checks++; if (htrans !== 2'b00) begin errors++; $display("FAIL reset_htrans got %h want 0", htrans); end
    checks++; if (m0_hresp !== 1'b0 || m1_hresp !== 1'b0) begin errors++; $display("FAIL reset_hresp got %b%b want 00", m0_hresp, m1_hresp); end
    checks++; if (m0_hready !== 1'b1 || m1_hready !== 1'b1) begin errors++; $display("FAIL reset_hready got %b%b want 11", m0_hready, m1_hready); end
    checks++; if (hburst !== 3'd0 || hmastlock !== 1'b0 || hprot !== 4'd0) begin errors++; $display("FAIL reset_const got %h %b %h want 0 0 0", hburst, hmastlock, hprot); end
    s_hrdata = 32'h5A5A_0001; mwdata[0] = 32'h0000_00F0; mwdata[1] = 32'h0000_00F1;
    #1;
    checks++; if (m1_hrdata !== 32'h5A5A_0001) begin errors++; $display("FAIL reset_hrdata got %h want 5a5a0001", m1_hrdata); end
    checks++; if (hwdata !== 32'h0000_00F0) begin errors++; $display("FAIL reset_hwdata got %h want f0", hwdata); end
    hresetn = 1;
    #1;
  endtask

  task automatic test_single();
    do_reset();
    maddr[0] = 32'h100; mtrans[0] = 2'b10;
    #1;
    checks++; if (haddr !== 32'h100) begin errors++; $display("FAIL single_haddr got %h want 100", haddr); end
    checks++; if (htrans !== 2'b10) begin errors++; $display("FAIL single_htrans got %h want 2", htrans); end
    checks++; if (m1_hready !== 1'b1) begin errors++; $display("FAIL single_m1_hready_a got %b want 1", m1_hready); end
    step();
    mtrans[0] = 2'b00; s_hrdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (m0_hrdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_hrdata got %h want deadbeef", m0_hrdata); end
    checks++; if (m1_hready !== 1'b1) begin errors++; $display("FAIL single_m1_hready_d got %b want 1", m1_hready); end
    step();
  endtask

  task automatic test_contention();
    do_reset();
    maddr[0] = 32'hA0; maddr[1] = 32'hB0; mtrans[0] = 2'b10; mtrans[1] = 2'b10;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] want_addr;
      want_addr = (k % 2 == 0) ? 32'hA0 : 32'hB0;
      #1;
      checks++; if (haddr !== want_addr) begin errors++; $display("FAIL rr_haddr[%0d] got %h want %h", k, haddr, want_addr); end
      checks++; if (m0_hready !== (k % 2 == 0) || m1_hready !== (k % 2 == 1)) begin
        errors++; $display("FAIL rr_hready[%0d] got %b%b want %b%b", k, m1_hready, m0_hready, k % 2 == 1, k % 2 == 0);
      end
      step();
    end
  endtask

  task automatic test_hold();
    do_reset();
    maddr[0] = 32'h200; mtrans[0] = 2'b10;
    #1; step();
    maddr[0] = 32'h204; maddr[1] = 32'h208; mtrans[1] = 2'b10; s_hrdata = 32'h1111_1111;
    #1;
    checks++; if (m0_hready !== 1'b0) begin errors++; $display("FAIL hold_stall got %b want 0", m0_hready); end
    checks++; if (haddr !== 32'h208) begin errors++; $display("FAIL hold_m1_addr got %h want 208", haddr); end
    step();
    mtrans[1] = 2'b00; s_hrdata = 32'h2222_2222;
    #1;
    checks++; if (m0_hready !== 1'b1) begin errors++; $display("FAIL hold_resume got %b want 1", m0_hready); end
    checks++; if (m0_hrdata !== 32'h1111_1111) begin errors++; $display("FAIL hold_data got %h want 11111111", m0_hrdata); end
    checks++; if (m1_hrdata !== 32'h2222_2222) begin errors++; $display("FAIL hold_m1_data got %h want 22222222", m1_hrdata); end
    checks++; if (haddr !== 32'h204) begin errors++; $display("FAIL hold_m0_addr got %h want 204", haddr); end
    step();
    mtrans[0] = 2'b00; s_hrdata = 32'h3333_3333;
    #1;
    checks++; if (m0_hrdata !== 32'h3333_3333) begin errors++; $display("FAIL hold_clear got %h want 33333333", m0_hrdata); end
    step();
  endtask

  task automatic test_wait_state();
    do_reset();
    maddr[1] = 32'h300; mwrite[1] = 1; mtrans[1] = 2'b10;
    #1; step();
    maddr[1] = 32'h304; mwdata[1] = 32'hCAFE_0001; s_hready = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin maddr[0] = 32'h400; mtrans[0] = 2'b10; end
      if (k == 3) s_hready = 1;
      #1;
      checks++; if (haddr !== 32'h304) begin errors++; $display("FAIL wait_haddr[%0d] got %h want 304", k, haddr); end
      checks++; if (hwdata !== 32'hCAFE_0001) begin errors++; $display("FAIL wait_hwdata[%0d] got %h want cafe0001", k, hwdata); end
      if (k >= 1) begin
        checks++; if (m0_hready !== 1'b0) begin errors++; $display("FAIL wait_m0_hready[%0d] got %b want 0", k, m0_hready); end
      end
      step();
    end
    mtrans[1] = 2'b00;
    #1;
    checks++; if (haddr !== 32'h400 || htrans !== 2'b10) begin errors++; $display("FAIL wait_m0_grant got %h/%h want 400/2", haddr, htrans); end
    step();
  endtask

  task automatic test_error();
    do_reset();
    maddr[0] = 32'h500; mtrans[0] = 2'b10;
    #1; step();
    mtrans[0] = 2'b00; s_hready = 0; s_hresp = 1;
    #1;
    checks++; if (m0_hresp !== 1'b1 || m0_hready !== 1'b0) begin errors++; $display("FAIL err_c1 got resp %b rdy %b want 1 0", m0_hresp, m0_hready); end
    checks++; if (m1_hresp !== 1'b0) begin errors++; $display("FAIL err_c1_m1 got %b want 0", m1_hresp); end
    step();
    s_hready = 1;
    #1;
    checks++; if (m0_hresp !== 1'b1 || m0_hready !== 1'b1) begin errors++; $display("FAIL err_c2 got resp %b rdy %b want 1 1", m0_hresp, m0_hready); end
    checks++; if (m1_hresp !== 1'b0) begin errors++; $display("FAIL err_c2_m1 got %b want 0", m1_hresp); end
    step();
    s_hresp = 0;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    maddr[0] = 32'h200; mtrans[0] = 2'b10;
    #1; step();
    maddr[0] = 32'h204; maddr[1] = 32'h208; mtrans[1] = 2'b10; s_hrdata = 32'h1111_1111;
    #1; step();
    mtrans[1] = 2'b00; mwdata[0] = 32'hAAAA_0000; mwdata[1] = 32'hBBBB_0000;
    s_hrdata = 32'h4444_4444; s_hresp = 1;
    #1;
    checks++; if (hwdata !== 32'hBBBB_0000) begin errors++; $display("FAIL rst_pre_hwdata got %h want bbbb0000", hwdata); end
    hresetn = 0;
    #1;
    model_reset();
    checks++; if (m0_hrdata !== 32'h4444_4444) begin errors++; $display("FAIL rst_held got %h want 44444444", m0_hrdata); end
    checks++; if (hwdata !== 32'hAAAA_0000) begin errors++; $display("FAIL rst_dpv got %h want aaaa0000", hwdata); end
    checks++; if (m1_hresp !== 1'b0 || m0_hresp !== 1'b0) begin errors++; $display("FAIL rst_hresp got %b%b want 00", m1_hresp, m0_hresp); end
    hresetn = 1; mtrans[0] = 2'b00; s_hresp = 0;
    #1; step();
    #1;
    checks++; if (htrans !== 2'b00) begin errors++; $display("FAIL rst_idle got %h want 0", htrans); end
    mtrans[0] = 2'b10; mtrans[1] = 2'b10;
    #1;
    checks++; if (haddr !== 32'h204) begin errors++; $display("FAIL rst_prio got %h want 204", haddr); end
    step();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        maddr[i]  = $urandom;
        mwrite[i] = 1'($urandom_range(0, 1));
        msize[i]  = 3'($urandom_range(0, 2));
        mtrans[i] = 2'($urandom_range(0, 3));
        mwdata[i] = $urandom;
      end
      s_hrdata = $urandom;
      s_hready = ($urandom_range(0, 3) != 0);
      s_hresp  = ($urandom_range(0, 7) == 0);
      #1;
      model_eval();
      checks++; if (haddr !== e_haddr || hwrite !== e_hwrite || hsize !== e_hsize) begin
        errors++; $display("FAIL rnd_addr[%0d] got %h/%b/%h want %h/%b/%h", n, haddr, hwrite, hsize, e_haddr, e_hwrite, e_hsize);
      end
      checks++; if (htrans !== e_htrans) begin errors++; $display("FAIL rnd_htrans[%0d] got %h want %h", n, htrans, e_htrans); end
      checks++; if (hwdata !== e_hwdata) begin errors++; $display("FAIL rnd_hwdata[%0d] got %h want %h", n, hwdata, e_hwdata); end
      checks++; if (m0_hready !== e_hready[0] || m1_hready !== e_hready[1]) begin
        errors++; $display("FAIL rnd_hready[%0d] got %b%b want %b%b", n, m1_hready, m0_hready, e_hready[1], e_hready[0]);
      end
      checks++; if (m0_hrdata !== e_hrdata[0]) begin errors++; $display("FAIL rnd_m0_hrdata[%0d] got %h want %h", n, m0_hrdata, e_hrdata[0]); end
      checks++; if (m1_hrdata !== e_hrdata[1]) begin errors++; $display("FAIL rnd_m1_hrdata[%0d] got %h want %h", n, m1_hrdata, e_hrdata[1]); end
      checks++; if (m0_hresp !== e_hresp[0] || m1_hresp !== e_hresp[1]) begin
        errors++; $display("FAIL rnd_hresp[%0d] got %b%b want %b%b", n, m1_hresp, m0_hresp, e_hresp[1], e_hresp[0]);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_hold();
    test_wait_state();
    test_error();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
